// File: rtl/inst_rom_arbiter.sv
// inst_rom_arbiter: shares the single-port instruction ROM between IF fetches and
// MEM-stage literal loads. Define INST_ROM_ALIGN_CHECK_EN to flag misaligned loads.
module inst_rom_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_taken,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_taken_o,
  input  logic              ls_req,
  input  logic [ADDR_W-1:0] ls_addr,
  output logic              ls_gnt,
  output logic              ls_valid,
  output logic [DATA_W-1:0] ls_data,
  output logic              ls_err,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_taken,
  input  logic [DATA_W-1:0] rom_inst,
  input  logic              rom_taken_in
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_LS = 2'd2
  } state_e;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  state_e            state_q, state_d;
  logic [2:0]        starve_q, starve_d;
  logic [DATA_W-1:0] if_inst_q, if_inst_d;
  logic [DATA_W-1:0] ls_data_q, ls_data_d;
  logic              if_taken_q, if_taken_d;
  logic              ls_err_q, ls_err_d;
  logic              ls_win;
  logic              ls_misalign;

`ifdef INST_ROM_ALIGN_CHECK_EN
  assign ls_misalign = (ls_addr[1:0] != 2'b00);
`else
  assign ls_misalign = 1'b0;
`endif

  // Arbitration: loads win when IF is idle or IF has starved them long enough.
  always_comb begin
    ls_win = ls_req && (!if_req || (starve_q == STARVE_LIM));
    ls_gnt = rst && ls_win;
    if_gnt = rst && if_req && !ls_win;
  end

  assign rom_ce    = if_gnt | ls_gnt;
  assign rom_addr  = if_gnt ? if_addr : (ls_gnt ? ls_addr : {ADDR_W{1'b0}});
  assign rom_taken = if_gnt & if_taken;

  // Next response state, captured read data and starvation count.
  always_comb begin
    state_d    = IDLE;
    if_inst_d  = if_inst_q;
    if_taken_d = if_taken_q;
    ls_data_d  = ls_data_q;
    ls_err_d   = 1'b0;
    starve_d   = starve_q;
    if (ls_gnt) begin
      state_d   = RESP_LS;
      ls_data_d = ls_misalign ? {DATA_W{1'b0}} : rom_inst;
      ls_err_d  = ls_misalign;
    end else if (if_gnt && !if_flush) begin
      state_d    = RESP_IF;
      if_inst_d  = rom_inst;
      if_taken_d = rom_taken_in;
    end else begin
      state_d = IDLE;
    end
    if (ls_gnt || !ls_req) begin
      starve_d = 3'd0;
    end else if (if_gnt && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 3'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  // State and response registers; reset discards any pending response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      starve_q   <= 3'd0;
      if_inst_q  <= {DATA_W{1'b0}};
      if_taken_q <= 1'b0;
      ls_data_q  <= {DATA_W{1'b0}};
      ls_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      if_inst_q  <= if_inst_d;
      if_taken_q <= if_taken_d;
      ls_data_q  <= ls_data_d;
      ls_err_q   <= ls_err_d;
    end
  end

  assign if_valid   = (state_q == RESP_IF);
  assign ls_valid   = (state_q == RESP_LS);
  assign if_inst    = if_inst_q;
  assign if_taken_o = if_taken_q;
  assign ls_data    = ls_data_q;
  assign ls_err     = ls_err_q;

endmodule
